// File: rtl/pe_context_sequencer_pkg.sv
// Shared types and constants for the PE context sequencer and its context store.
package pe_ctx_pkg;

  // Width of one configuration write word.
  localparam int CFG_WORD_W = 32;

  // Word index within a context: three config-bit words, then the dwell count.
  localparam logic [1:0] WORD_CFG0  = 2'd0;
  localparam logic [1:0] WORD_CFG1  = 2'd1;
  localparam logic [1:0] WORD_CFG2  = 2'd2;
  localparam logic [1:0] WORD_DWELL = 2'd3;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Clamp a requested final-context index to the last physically stored context.
  function automatic int clamp_last(input int last, input int num_ctx);
    return (last > num_ctx - 1) ? (num_ctx - 1) : last;
  endfunction

endpackage

// File: rtl/pe_context_sequencer_if.sv
// Configuration write bus into the context sequencer: valid/ready handshake
// carrying a target context, a word index and 32 bits of data.
interface pe_context_sequencer_if #(
  parameter int CTX_W = 2
);
  import pe_ctx_pkg::*;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CTX_W-1:0]      cfg_ctx;
  logic [1:0]            cfg_word;
  logic [CFG_WORD_W-1:0] cfg_data;

  // Configuration loader side.
  modport master (
    output cfg_valid,
    output cfg_ctx,
    output cfg_word,
    output cfg_data,
    input  cfg_ready
  );

  // Sequencer side.
  modport slave (
    input  cfg_valid,
    input  cfg_ctx,
    input  cfg_word,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/pe_context_sequencer_store.sv
// Register file holding NUM_CONTEXTS switch-matrix configurations plus a dwell
// count per context. Word-addressed write port, combinational read port.
module pe_context_store
  import pe_ctx_pkg::*;
#(
  parameter int NoConfigBits = 65,
  parameter int NUM_CONTEXTS = 4,
  parameter int CTX_W        = $clog2(NUM_CONTEXTS),
  parameter int DWELL_W      = 16
) (
  input  logic                    UserCLK,
  input  logic                    reset,
  input  logic                    wr_en_i,
  input  logic [CTX_W-1:0]        wr_ctx_i,
  input  logic [1:0]              wr_word_i,
  input  logic [CFG_WORD_W-1:0]   wr_data_i,
  input  logic [CTX_W-1:0]        rd_ctx_i,
  output logic [NoConfigBits-1:0] rd_cfg_o,
  output logic [DWELL_W-1:0]      rd_dwell_o
);

  logic [NoConfigBits-1:0] cfg_mem_q   [NUM_CONTEXTS];
  logic [DWELL_W-1:0]      dwell_mem_q [NUM_CONTEXTS];

  // Clear on reset; otherwise update the addressed word of the addressed context.
  always_ff @(posedge UserCLK) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values.
    if (reset) begin
      // NOTE: this storage is cleared on reset because a fresh tile must drive
      // a known all-zero schedule, so it maps to flops rather than a RAM macro.
      for (int c = 0; c < NUM_CONTEXTS; c++) begin
        cfg_mem_q[c]   <= '0;
        dwell_mem_q[c] <= '0;
      end
    end else if (wr_en_i) begin
      if (wr_word_i == WORD_DWELL) begin
        // Dwell bits above DWELL_W are dropped.
        dwell_mem_q[wr_ctx_i] <= wr_data_i[DWELL_W-1:0];
      end else begin
        // Only select bits that exist are written; the rest of the word is dropped.
        for (int b = 0; b < NoConfigBits; b++) begin
          if ((b / CFG_WORD_W) == int'(wr_word_i)) begin
            cfg_mem_q[wr_ctx_i][b] <= wr_data_i[b % CFG_WORD_W];
          end
        end
      end
    end
  end

  assign rd_cfg_o   = cfg_mem_q[rd_ctx_i];
  assign rd_dwell_o = dwell_mem_q[rd_ctx_i];

endmodule

// File: rtl/pe_context_sequencer.sv
// Multi-context switch-matrix sequencer. Steps the tile through stored
// configurations, holding each for its dwell count, turning a static routing
// into a time-multiplexed schedule on the ConfigBits select bus.
module pe_context_sequencer
  import pe_ctx_pkg::*;
#(
  parameter int NoConfigBits = 65,
  parameter int NUM_CONTEXTS = 4,
  parameter int CTX_W        = $clog2(NUM_CONTEXTS),
  parameter int DWELL_W      = 16
) (
  input  logic                    UserCLK,
  input  logic                    reset,
  pe_context_sequencer_if.slave   cfg,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [CTX_W-1:0]        last_ctx,
  output logic                    busy,
  output logic                    done,
  output logic [CTX_W-1:0]        ctx_id,
  output logic                    ctx_switch,
  output logic [NoConfigBits-1:0] ConfigBits,
  output logic [NoConfigBits-1:0] ConfigBits_N
);

  state_e                  state_q;
  logic [CTX_W-1:0]        ctx_id_q;
  logic [DWELL_W-1:0]      dwell_cnt_q;
  logic [NoConfigBits-1:0] config_bits_q;

  logic [NoConfigBits-1:0] rd_cfg;
  logic [DWELL_W-1:0]      rd_dwell;
  logic                    wr_en;
  logic [CTX_W-1:0]        eff_last;
  logic                    dwell_zero;
  logic                    at_last;

  // Writes are only accepted while the schedule is not running, so the
  // context being driven can never change underneath the switch matrix.
  assign cfg.cfg_ready = (state_q == IDLE);
  assign wr_en         = cfg.cfg_valid & cfg.cfg_ready;

  pe_context_store #(
    .NoConfigBits (NoConfigBits),
    .NUM_CONTEXTS (NUM_CONTEXTS),
    .CTX_W        (CTX_W),
    .DWELL_W      (DWELL_W)
  ) u_store (
    .UserCLK    (UserCLK),
    .reset      (reset),
    .wr_en_i    (wr_en),
    .wr_ctx_i   (cfg.cfg_ctx),
    .wr_word_i  (cfg.cfg_word),
    .wr_data_i  (cfg.cfg_data),
    .rd_ctx_i   (ctx_id_q),
    .rd_cfg_o   (rd_cfg),
    .rd_dwell_o (rd_dwell)
  );

  // last_ctx is live: it is read at the moment each advance/wrap decision is made.
  assign eff_last   = CTX_W'(clamp_last(int'(last_ctx), NUM_CONTEXTS));
  assign dwell_zero = (dwell_cnt_q == '0);
  assign at_last    = (ctx_id_q == eff_last);

  // Schedule FSM: IDLE waits for start, APPLY loads one context, RUN dwells on it.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q       <= IDLE;
      ctx_id_q      <= '0;
      dwell_cnt_q   <= '0;
      config_bits_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            ctx_id_q <= '0;
            state_q  <= APPLY;
          end
        end
        APPLY: begin
          // An abort here skips the load so the previous context stays on the bus.
          if (stop) begin
            state_q <= IDLE;
          end else begin
            config_bits_q <= rd_cfg;
            dwell_cnt_q   <= rd_dwell;
            state_q       <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (!dwell_zero) begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end else if (!at_last) begin
            ctx_id_q <= ctx_id_q + CTX_W'(1);
            state_q  <= APPLY;
          end else if (loop_en) begin
            ctx_id_q <= '0;
            state_q  <= APPLY;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status decoded straight from the state register; done is the one output
  // that depends on live inputs because loop_en and stop decide completion.
  assign busy       = (state_q != IDLE);
  assign ctx_switch = (state_q == APPLY);
  assign done       = (state_q == RUN) && !stop && dwell_zero && at_last && !loop_en;
  assign ctx_id     = ctx_id_q;

  assign ConfigBits   = config_bits_q;
  assign ConfigBits_N = ~config_bits_q;

endmodule

// File: tb/tb_pe_context_sequencer.sv
// Directed bench for pe_context_sequencer. A small model of the stored
// contexts builds the expected per-cycle output trace into a scoreboard when
// each schedule is launched; every cycle pops one entry and compares it.
`timescale 1ns/1ps
module tb_pe_context_sequencer;
  import pe_ctx_pkg::*;

  localparam int NCB   = 65;
  localparam int NCTX  = 4;
  localparam int CTX_W = 2;
  localparam int DW    = 16;

  logic             UserCLK = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             loop_en;
  logic [CTX_W-1:0] last_ctx;
  logic             busy;
  logic             done;
  logic [CTX_W-1:0] ctx_id;
  logic             ctx_switch;
  logic [NCB-1:0]   ConfigBits;
  logic [NCB-1:0]   ConfigBits_N;

  pe_context_sequencer_if #(.CTX_W(CTX_W)) cfg_if ();

  pe_context_sequencer #(
    .NoConfigBits (NCB),
    .NUM_CONTEXTS (NCTX),
    .CTX_W        (CTX_W),
    .DWELL_W      (DW)
  ) dut (
    .UserCLK      (UserCLK),
    .reset        (reset),
    .cfg          (cfg_if),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .last_ctx     (last_ctx),
    .busy         (busy),
    .done         (done),
    .ctx_id       (ctx_id),
    .ctx_switch   (ctx_switch),
    .ConfigBits   (ConfigBits),
    .ConfigBits_N (ConfigBits_N)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic [CTX_W-1:0] ctx;
    logic             sw;
    logic             dn;
    logic             bsy;
    logic [NCB-1:0]   cb;
  } exp_t;

  exp_t             sb_q[$];
  logic [NCB-1:0]   m_cfg   [NCTX];
  logic [DW-1:0]    m_dwell [NCTX];
  logic [NCB-1:0]   m_cb;
  logic [CTX_W-1:0] m_ctx;
  int               total = 0;
  int               bad   = 0;

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [NCB-1:0] obs, input logic [NCB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [CTX_W-1:0] c, input logic sw, input logic dn,
                      input logic bsy, input logic [NCB-1:0] cb);
    exp_t e;
    e.ctx = c; e.sw = sw; e.dn = dn; e.bsy = bsy; e.cb = cb;
    sb_q.push_back(e);
  endtask

  task automatic push_apply(input int c);
    m_ctx = CTX_W'(c);
    push(m_ctx, 1'b1, 1'b0, 1'b1, m_cb);
  endtask

  task automatic push_run(input int c, input int n, input bit last_done);
    m_cb = m_cfg[c];
    for (int i = 0; i < n; i++)
      push(CTX_W'(c), 1'b0, (last_done && i == n - 1), 1'b1, m_cb);
  endtask

  task automatic push_idle();
    push(m_ctx, 1'b0, 1'b0, 1'b0, m_cb);
  endtask

  // One pass over contexts 0..last; a final pass ends with done on its last RUN cycle.
  task automatic push_pass(input int last, input bit final_pass);
    for (int c = 0; c <= last; c++) begin
      push_apply(c);
      push_run(c, int'(m_dwell[c]) + 1, final_pass && c == last);
    end
  endtask

  task automatic check_cycle(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.underflow: observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".ctx_id"},  NCB'(ctx_id),        NCB'(e.ctx));
      check({tag, ".switch"},  NCB'(ctx_switch),    NCB'(e.sw));
      check({tag, ".done"},    NCB'(done),          NCB'(e.dn));
      check({tag, ".busy"},    NCB'(busy),          NCB'(e.bsy));
      check({tag, ".ready"},   NCB'(cfg_if.cfg_ready), NCB'(!e.bsy));
      check({tag, ".cfg"},     ConfigBits,          e.cb);
      check({tag, ".cfg_n"},   ConfigBits_N,        ~e.cb);
    end
  endtask

  task automatic run_checked(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check_cycle(tag);
      tick();
    end
  endtask

  task automatic model_write(input int c, input logic [1:0] w, input logic [31:0] d);
    logic [95:0] t;
    if (w == WORD_DWELL) begin
      m_dwell[c] = d[DW-1:0];
    end else begin
      t = 96'(m_cfg[c]);
      t[int'(w)*32 +: 32] = d;
      m_cfg[c] = t[NCB-1:0];
    end
  endtask

  task automatic write(input int c, input logic [1:0] w, input logic [31:0] d);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ctx   = CTX_W'(c);
    cfg_if.cfg_word  = w;
    cfg_if.cfg_data  = d;
    check("wr_ready", NCB'(cfg_if.cfg_ready), NCB'(1'b1));
    tick();
    cfg_if.cfg_valid = 1'b0;
    model_write(c, w, d);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCTX; c++) begin
      m_cfg[c]   = '0;
      m_dwell[c] = '0;
    end
    m_cb  = '0;
    m_ctx = '0;
  endtask

  // Current cycle is IDLE with start raised; the schedule begins at the next edge.
  task automatic launch(input string tag);
    start = 1'b1;
    push_idle();
    check_cycle(tag);
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_ctx = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ctx = '0; cfg_if.cfg_word = '0; cfg_if.cfg_data = '0;
    model_reset();
    tick();
    tick();

    // Reset state, then idle after release.
    push_idle();
    check_cycle("reset");
    reset = 1'b0;
    tick();
    push_idle();
    check_cycle("idle");

    // Two-context schedule, no looping.
    write(0, WORD_CFG0, 32'h0000_0003);
    write(0, WORD_CFG1, 32'h0000_0000);
    write(0, WORD_CFG2, 32'h0000_0001);
    write(0, WORD_DWELL, 32'd2);
    write(1, WORD_CFG0, 32'hFFFF_FFFF);
    write(1, WORD_CFG1, 32'h0000_0000);
    write(1, WORD_CFG2, 32'h0000_0000);
    write(1, WORD_DWELL, 32'd0);
    check("model_ctx0", m_cfg[0], 65'h1_0000_0000_0000_0003);
    last_ctx = CTX_W'(1);
    loop_en  = 1'b0;
    launch("run1_start");
    push_pass(1, 1'b1);
    push_idle();
    run_checked(sb_q.size(), "run1");

    // Same schedule looping twice, then loop_en dropped for a final pass.
    loop_en = 1'b1;
    launch("loop_start");
    push_pass(1, 1'b0);
    push_pass(1, 1'b0);
    run_checked(12, "loop");
    loop_en = 1'b0;
    push_pass(1, 1'b1);
    push_idle();
    run_checked(sb_q.size(), "loop_end");

    // Write held through a busy schedule; accepted in the first IDLE cycle.
    launch("wrbusy_start");
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ctx   = CTX_W'(0);
    cfg_if.cfg_word  = WORD_CFG0;
    cfg_if.cfg_data  = 32'h0000_0005;
    push_pass(1, 1'b1);
    run_checked(sb_q.size(), "wrbusy");
    push_idle();
    check_cycle("wr_idle");
    tick();
    cfg_if.cfg_valid = 1'b0;
    model_write(0, WORD_CFG0, 32'h0000_0005);
    push_idle();
    check_cycle("after_wr");

    // Out-of-range config bits and upper dwell bits are dropped.
    write(1, WORD_CFG2, 32'hFFFF_FFFF);
    write(0, WORD_DWELL, 32'hABCD_0001);
    check("model_ctx1", m_cfg[1], 65'h1_0000_0000_FFFF_FFFF);
    launch("rdback_start");
    push_pass(1, 1'b1);
    push_idle();
    run_checked(sb_q.size(), "rdback");

    // stop during APPLY: no load, straight back to IDLE.
    launch("stopA_start");
    stop = 1'b1;
    push_apply(0);
    check_cycle("stopA");
    tick();
    stop = 1'b0;
    push_idle();
    check_cycle("stopA_idle");

    // stop and start together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    push_idle();
    check_cycle("stopstart");
    tick();
    start = 1'b0;
    stop  = 1'b0;
    push_idle();
    check_cycle("stopstart_idle");

    // stop in a RUN cycle of ctx1.
    write(1, WORD_DWELL, 32'd3);
    launch("stopR_start");
    push_apply(0);
    push_run(0, int'(m_dwell[0]) + 1, 1'b0);
    push_apply(1);
    push_run(1, 2, 1'b0);
    run_checked(sb_q.size() - 1, "stopR_pre");
    stop = 1'b1;
    check_cycle("stopR");
    tick();
    stop = 1'b0;
    push_idle();
    check_cycle("stopR_idle");

    // last_ctx beyond the stored range (7 truncated to the 2-bit port) runs all four contexts.
    write(2, WORD_CFG0, 32'h1234_5678);
    write(2, WORD_CFG1, 32'h9ABC_DEF0);
    write(2, WORD_DWELL, 32'd0);
    write(3, WORD_CFG0, 32'hDEAD_BEEF);
    write(3, WORD_CFG2, 32'h0000_0001);
    write(3, WORD_DWELL, 32'd1);
    last_ctx = CTX_W'(7);
    launch("all_start");
    push_pass(NCTX - 1, 1'b1);
    push_idle();
    run_checked(sb_q.size(), "all");

    // Reset in the middle of RUN.
    last_ctx = CTX_W'(1);
    loop_en  = 1'b1;
    launch("rstmid_start");
    push_apply(0);
    push_run(0, int'(m_dwell[0]) + 1, 1'b0);
    run_checked(sb_q.size() - 1, "rstmid_pre");
    reset = 1'b1;
    check_cycle("rstmid_run");
    tick();
    model_reset();
    push_idle();
    check_cycle("rstmid");
    reset   = 1'b0;
    loop_en = 1'b0;
    tick();

    // Storage was cleared by reset: the schedule drives zeros.
    launch("cleared_start");
    push_pass(1, 1'b1);
    push_idle();
    run_checked(sb_q.size(), "cleared");

    check("sb_empty", NCB'(sb_q.size()), NCB'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
